alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Single-issue front-end to the base ALU: accepts one RV32I OP/OP-IMM instruction per valid/ready handshake.
- Decodes fields and reads operands from an internal 32x32 register file.
- Drives the ALU's enable, funct3 and two operand inputs, captures the ALU result, writes it back to rd, and signals retirement.
- Sits directly upstream (operand/control provider) and downstream (result consumer) of alu_base.

Parameters:
ALU_LATENCY, 1, cycles alu_enable is held before the result is sampled (legal 1..15)
REG_COUNT, 32, architectural registers; index 0 hardwired to zero

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  upstream instruction present
instr_ready  output  1  stage can accept an instruction
instruction  input  32  RV32I instruction word
alu_enable  output  1  enable to ALU
alu_funct3  output  3  funct3 to ALU
alu_register_data_1  output  32  operand 1 to ALU (rs1 value)
alu_register_data_2  output  32  operand 2 to ALU (rs2 value or sign-extended imm)
alu_register_data_out  input  32  ALU result
retire_valid  output  1  one-cycle pulse: instruction retired
retire_rd  output  5  destination index of retired instruction
retire_data  output  32  value written (or discarded if rd=0)
illegal  output  1  one-cycle pulse: unsupported opcode dropped

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; all register file entries 0; EXEC counter 0. instr_ready is 0 while reset is high.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch the instruction.
  - Opcode 0110011 (OP) or 0010011 (OP-IMM): go to READ.
  - Any other opcode: pulse illegal next cycle, stay IDLE.
- READ (1 cycle): register rs1 value into alu_register_data_1.
  - OP: rs2 value into alu_register_data_2.
  - OP-IMM: {{20{instr[31]}},instr[31:20]} into alu_register_data_2.
  - instr[14:12] into alu_funct3. funct7 is not forwarded.
- EXEC: alu_enable=1 for exactly ALU_LATENCY cycles; operands and funct3 held stable. alu_register_data_out is sampled on the edge ending the last EXEC cycle.
- WB (1 cycle): retire_valid=1, retire_rd=rd, retire_data=captured result. Register file written at the end of WB unless rd=0; x0 always reads 0.
- Return to IDLE after WB. instr_ready is 0 in READ/EXEC/WB.
- Latency: handshake at cycle N gives retire_valid at cycle N+2+ALU_LATENCY. Throughput is one instruction per 3+ALU_LATENCY cycles.
- Strict serialization: no RAW hazard; a dependent next instruction reads the value already written.
- Operands and funct3 hold their last values in IDLE. alu_enable=0 outside EXEC.
- instr_valid deasserted mid-operation has no effect. instruction is only sampled on the handshake.
- Reset in any state aborts the instruction: no retire pulse, no write, register file cleared.

Optional Feature:
ALU_ISSUE_DEBUG_PORT_EN:
- Defined: adds input debug_addr[4:0] and output debug_data[31:0], a combinational read of the register file (0 for addr 0). The read is side-effect free and usable in any state.
- Undefined: ports absent; no debug read logic.

Test Plan:
- Reset release, ALU_LATENCY=1: ADDI x1,x0,5 (0x00500093) -> alu_funct3=0, operands 0/5, alu_enable high 1 cycle, retire at N+3 with rd=1, data=5; debug_data(1)=5.
- With x1=5, ADDI x2,x0,-3 then ADD x3,x1,x2 (0x002081B3) -> operands 0x00000005/0xFFFFFFFD, funct3=0; bench ALU model returns 2; x3=2.
- ADDI x0,x0,7 -> retire_valid with rd=0, data=7; x0 still reads 0.
- Opcode 0x0000006F (JAL) -> illegal pulses once, no retire_valid, no alu_enable, instr_ready stays 1.
- instr_valid held high continuously with two instructions, ALU_LATENCY=3 -> second accepted exactly 6 cycles after first; instr_ready low in between.
- Reset asserted during EXEC of ADDI x4,x0,9 -> outputs 0 immediately, no retire, x4=0 after release.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - instruction handshake, ALU drive and retire signals of alu_issue_stage
interface alu_issue_stage_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        alu_enable;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_register_data_1;
  logic [31:0] alu_register_data_2;
  logic [31:0] alu_register_data_out;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        illegal;

  modport master (
    output instr_valid, instruction, alu_register_data_out,
    input  instr_ready, alu_enable, alu_funct3, alu_register_data_1, alu_register_data_2,
    input  retire_valid, retire_rd, retire_data, illegal
  );

  modport slave (
    input  instr_valid, instruction, alu_register_data_out,
    output instr_ready, alu_enable, alu_funct3, alu_register_data_1, alu_register_data_2,
    output retire_valid, retire_rd, retire_data, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - serial RV32I OP/OP-IMM issue, ALU drive and writeback stage
// Optional ALU_ISSUE_DEBUG_PORT_EN adds a side-effect-free register file read port.
module alu_issue_stage #(
  parameter int ALU_LATENCY = 1,
  parameter int REG_COUNT   = 32
) (
  input  logic        clock,
  input  logic        reset,
`ifdef ALU_ISSUE_DEBUG_PORT_EN
  input  logic [4:0]  debug_addr,
  output logic [31:0] debug_data,
`endif
  alu_issue_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [3:0] LAST_EXEC = 4'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state, state_next;
  logic [31:0] instr_q;
  logic [31:0] result_q;
  logic [31:0] regs [REG_COUNT];
  logic [3:0]  exec_cnt;
  logic        illegal_q;
  logic        ready_int;
  logic        accept;
  logic        opcode_ok;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val, imm_val;

  assign rd      = instr_q[11:7];
  assign rs1     = instr_q[19:15];
  assign rs2     = instr_q[24:20];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm_val = {{20{instr_q[31]}}, instr_q[31:20]};

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign ready_int       = (state == IDLE) && !reset;
  assign bus.instr_ready = ready_int;
  assign accept          = bus.instr_valid && ready_int;
  assign opcode_ok       = (bus.instruction[6:0] == OPC_OP) || (bus.instruction[6:0] == OPC_OPIMM);
  assign bus.illegal     = illegal_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.alu_enable   = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_rd    = 5'd0;
    bus.retire_data  = 32'd0;
    case (state)
      IDLE: if (accept && opcode_ok) state_next = READ;
      READ: state_next = EXEC;
      EXEC: begin
        bus.alu_enable = 1'b1;
        if (exec_cnt == LAST_EXEC) state_next = WB;
      end
      WB: begin
        bus.retire_valid = 1'b1;
        bus.retire_rd    = rd;
        bus.retire_data  = result_q;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q                 <= 32'd0;
      result_q                <= 32'd0;
      exec_cnt                <= 4'd0;
      illegal_q               <= 1'b0;
      bus.alu_funct3          <= 3'd0;
      bus.alu_register_data_1 <= 32'd0;
      bus.alu_register_data_2 <= 32'd0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 32'd0;
    end else begin
      illegal_q <= accept && !opcode_ok;
      if (accept) instr_q <= bus.instruction;
      if (state == READ) begin
        bus.alu_funct3          <= instr_q[14:12];
        bus.alu_register_data_1 <= rs1_val;
        bus.alu_register_data_2 <= (instr_q[6:0] == OPC_OPIMM) ? imm_val : rs2_val;
        exec_cnt                <= 4'd0;
      end
      if (state == EXEC) begin
        exec_cnt <= exec_cnt + 4'd1;
        if (exec_cnt == LAST_EXEC) result_q <= bus.alu_register_data_out;
      end
      if ((state == WB) && (rd != 5'd0)) regs[rd] <= result_q;
    end
  end

`ifdef ALU_ISSUE_DEBUG_PORT_EN
  assign debug_data = (debug_addr == 5'd0) ? 32'd0 : regs[debug_addr];
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed bench for alu_issue_stage at ALU_LATENCY 1 and 3
module tb_alu_issue_stage;
  logic clock = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  alu_issue_stage_if bus_a();
  alu_issue_stage_if bus_b();

`ifdef ALU_ISSUE_DEBUG_PORT_EN
  logic [4:0]  dbg_addr_a, dbg_addr_b;
  logic [31:0] dbg_data_a, dbg_data_b;
  initial begin dbg_addr_a = 5'd0; dbg_addr_b = 5'd0; end
`endif

  alu_issue_stage #(.ALU_LATENCY(1)) dut_a (
    .clock(clock), .reset(rst_a),
`ifdef ALU_ISSUE_DEBUG_PORT_EN
    .debug_addr(dbg_addr_a), .debug_data(dbg_data_a),
`endif
    .bus(bus_a)
  );

  alu_issue_stage #(.ALU_LATENCY(3)) dut_b (
    .clock(clock), .reset(rst_b),
`ifdef ALU_ISSUE_DEBUG_PORT_EN
    .debug_addr(dbg_addr_b), .debug_data(dbg_data_b),
`endif
    .bus(bus_b)
  );

  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return a + b;
    endcase
  endfunction

  always_comb bus_a.alu_register_data_out = alu_model(bus_a.alu_funct3, bus_a.alu_register_data_1, bus_a.alu_register_data_2);
  always_comb bus_b.alu_register_data_out = alu_model(bus_b.alu_funct3, bus_b.alu_register_data_1, bus_b.alu_register_data_2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  int          r_k, r_n, e_n, il_n, rl_n;
  logic [4:0]  r_rd;
  logic [31:0] r_data, o1, o2;
  logic [2:0]  f3;

  // One instruction on DUT A, then 8 observed cycles (k counts cycles after the handshake).
  task automatic run_a(input logic [31:0] ins);
    r_k = 0; r_n = 0; e_n = 0; il_n = 0; rl_n = 0;
    r_rd = 5'h1f; r_data = 32'hdeadbeef; o1 = 32'hdeadbeef; o2 = 32'hdeadbeef; f3 = 3'd5;
    @(negedge clock);
    bus_a.instruction = ins;
    bus_a.instr_valid = 1'b1;
    @(posedge clock);
    #1 bus_a.instr_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (bus_a.retire_valid) begin
        r_n++;
        if (r_k == 0) begin r_k = k; r_rd = bus_a.retire_rd; r_data = bus_a.retire_data; end
      end
      if (bus_a.alu_enable) begin
        e_n++; o1 = bus_a.alu_register_data_1; o2 = bus_a.alu_register_data_2; f3 = bus_a.alu_funct3;
      end
      if (bus_a.illegal) il_n++;
      if (!bus_a.instr_ready) rl_n++;
    end
  endtask

  int          acc, rk1, rk2, seen;
  logic [31:0] rd1, rd2;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.instr_valid = 1'b0; bus_a.instruction = 32'd0;
    bus_b.instr_valid = 1'b0; bus_b.instruction = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_ready",   32'(bus_a.instr_ready), 32'd0);
    check("rst_enable",  32'(bus_a.alu_enable), 32'd0);
    check("rst_retire",  32'(bus_a.retire_valid), 32'd0);
    check("rst_illegal", 32'(bus_a.illegal), 32'd0);
    check("rst_op1",     bus_a.alu_register_data_1, 32'd0);
    check("rst_op2",     bus_a.alu_register_data_2, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1 check("ready_after_rst", 32'(bus_a.instr_ready), 32'd1);

    run_a(32'h00500093);
    check("addi_ret_k",  r_k, 3);
    check("addi_ret_n",  r_n, 1);
    check("addi_rd",     32'(r_rd), 32'd1);
    check("addi_data",   r_data, 32'd5);
    check("addi_en_n",   e_n, 1);
    check("addi_op1",    o1, 32'd0);
    check("addi_op2",    o2, 32'd5);
    check("addi_f3",     32'(f3), 32'd0);
`ifdef ALU_ISSUE_DEBUG_PORT_EN
    dbg_addr_a = 5'd1;
    #1 check("debug_x1", dbg_data_a, 32'd5);
`endif

    run_a(32'hFFD00113);
    check("addi_neg_op2",  o2, 32'hFFFFFFFD);
    check("addi_neg_data", r_data, 32'hFFFFFFFD);
    run_a(32'h002081B3);
    check("add_op1",  o1, 32'd5);
    check("add_op2",  o2, 32'hFFFFFFFD);
    check("add_f3",   32'(f3), 32'd0);
    check("add_rd",   32'(r_rd), 32'd3);
    check("add_data", r_data, 32'd2);
    run_a(32'h00018293);
    check("x3_read", o1, 32'd2);
    run_a(32'h00C0F313);
    check("andi_f3",   32'(f3), 32'd7);
    check("andi_op2",  o2, 32'd12);
    check("andi_data", r_data, 32'd4);

    run_a(32'h00700013);
    check("x0_ret_n", r_n, 1);
    check("x0_rd",    32'(r_rd), 32'd0);
    check("x0_data",  r_data, 32'd7);
    run_a(32'h00100393);
    check("x0_reads_zero", o1, 32'd0);

    run_a(32'h0000006F);
    check("jal_illegal_n", il_n, 1);
    check("jal_retire_n",  r_n, 0);
    check("jal_enable_n",  e_n, 0);
    check("jal_ready_low", rl_n, 0);

    // Back-to-back issue on DUT B with instr_valid held high.
    acc = 0; rl_n = 0; rk1 = 0; rk2 = 0; rd1 = 32'd0; rd2 = 32'd0; e_n = 0;
    @(negedge clock);
    bus_b.instruction = 32'h00500093;
    bus_b.instr_valid = 1'b1;
    @(posedge clock);
    #1 bus_b.instruction = 32'h00108113;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (bus_b.alu_enable) e_n++;
      if (bus_b.retire_valid) begin
        if (rk1 == 0) begin rk1 = k; rd1 = bus_b.retire_data; end
        else if (rk2 == 0) begin rk2 = k; rd2 = bus_b.retire_data; end
      end
      if (acc == 0) begin
        if (bus_b.instr_ready) begin
          acc = k;
          @(posedge clock);
          #1 bus_b.instr_valid = 1'b0;
        end else rl_n++;
      end
    end
    bus_b.instr_valid = 1'b0;
    check("b2b_accept_k", acc, 6);
    check("b2b_ready_low", rl_n, 5);
    check("b2b_ret1_k",   rk1, 5);
    check("b2b_ret1_data", rd1, 32'd5);
    check("b2b_ret2_k",   rk2, 11);
    check("b2b_ret2_data", rd2, 32'd6);
    check("b2b_enable_n", e_n, 6);

    // Reset during EXEC on DUT B aborts the instruction and clears the register file.
    seen = 0;
    @(negedge clock);
    bus_b.instruction = 32'h00900213;
    bus_b.instr_valid = 1'b1;
    @(posedge clock);
    #1 bus_b.instr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (seen == 0 && bus_b.alu_enable) begin
        seen = 1;
        rst_b = 1'b1;
        #1;
        check("exec_rst_op2",    bus_b.alu_register_data_2, 32'd0);
        check("exec_rst_enable", 32'(bus_b.alu_enable), 32'd0);
        check("exec_rst_ready",  32'(bus_b.instr_ready), 32'd0);
        check("exec_rst_retire", 32'(bus_b.retire_valid), 32'd0);
      end
    end
    check("exec_seen", seen, 1);
    @(negedge clock);
    rst_b = 1'b0;
    r_n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (bus_b.retire_valid) r_n++;
    end
    check("abort_no_retire", r_n, 0);

    r_n = 0; o1 = 32'hdeadbeef; o2 = 32'hdeadbeef; r_data = 32'hdeadbeef;
    @(negedge clock);
    bus_b.instruction = 32'h001202B3;
    bus_b.instr_valid = 1'b1;
    @(posedge clock);
    #1 bus_b.instr_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (bus_b.alu_enable) begin o1 = bus_b.alu_register_data_1; o2 = bus_b.alu_register_data_2; end
      if (bus_b.retire_valid) begin r_n++; r_data = bus_b.retire_data; end
    end
    check("x4_cleared",  o1, 32'd0);
    check("x1_cleared",  o2, 32'd0);
    check("post_rst_ret_n", r_n, 1);
    check("post_rst_data",  r_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
